ifmap_window_gen: RTL and testbench
===================================

# ifmap_window_gen

Streaming 3x3 window generator that sits directly upstream of the PE tensor's `ifmap` port. It accepts one 8-bit input-feature-map pixel per cycle in raster order, buffers the two previous image rows internally, and emits every valid (unpadded, stride-1) 3x3 neighbourhood as one 72-bit packed window. It also reports the window position and marks the last window of each frame. N tensor lanes are fed by instantiating N copies or by fanning out one copy.

## Interface
- `IMG_W`, default 8: image width in pixels; legal values are ≥3.
- `IMG_H`, default 8: image height in pixels; legal values are ≥3.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous frame abort; clears counters and the output valid.
- `pixel_in` input 8: incoming pixel, unsigned byte.
- `pixel_valid` input 1: `pixel_in` is accepted on this edge. There is no backpressure.
- `ifmap` output 72: packed 3x3 window; feeds pe_tensor `ifmap` slice.
- `ifmap_valid` output 1: `ifmap` holds a new window this cycle (one-cycle pulse per window).
- `win_row` output $clog2(IMG_H): image row of the window's top-left element.
- `win_col` output $clog2(IMG_W): image column of the window's top-left element.
- `frame_done` output 1: one-cycle pulse coincident with the last window of a frame.

## Operation
- **Counters:** `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance only on an accepted pixel.
  - `col` wraps to 0 at IMG_W-1, and `row` increments on that wrap.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts.
- **Line buffers:** `lb0` holds row-1 and `lb1` holds row-2. Each has IMG_W × 8 bits and is indexed by `col`.
- **On each accepted pixel p at (row, col):**
  - Form column vector {top = `lb1[col]`, mid = `lb0[col]`, bot = p}.
  - Write `lb1[col]` ← `lb0[col]` and `lb0[col]` ← p.
  - Shift the 3x3 window register left by one column. The vector enters column 2, the rightmost column.
- **Window validity:** a window is valid when `row ≥ 2` and `col ≥ 2`, evaluated on the accepted pixel's coordinates.
  - Windows that straddle a row wrap (col < 2) are never emitted.
  - Line-buffer garbage from a previous frame is never emitted (row < 2).
- **Packing:** element k = 3·r + c occupies `ifmap[8k+7:8k]`.
  - r = 0 is the top (oldest) row; c = 0 is the leftmost (oldest) column.
  - So byte 0 is the top-left element and byte 8 is the bottom-right element, which is the newest pixel.
- **Window position:** `win_row` = row − 2 and `win_col` = col − 2 of the completing pixel.
- **Window count:** exactly (IMG_W−2)·(IMG_H−2) windows are emitted per frame.
- **`frame_done`:** asserted with the window completed by pixel (IMG_H−1, IMG_W−1).
- **`flush`:**
  - Zeroes `row`, `col` and `ifmap_valid`, and deasserts `frame_done`.
  - Line-buffer contents are left as-is; they are don't-care.
  - When `flush` and `pixel_valid` occur in the same cycle, `flush` wins and the pixel is dropped.
- **`rst`:**
  - Clears `row`, `col`, the window register, `ifmap` (0), `ifmap_valid` (0), `win_row` (0), `win_col` (0) and `frame_done` (0).
  - Line buffers are not reset.
  - `rst` mid-frame discards the partial frame; the next accepted pixel is (0,0).

## Timing
- All outputs are registered. The window, the valid flag, the position and `frame_done` appear one cycle after the edge that accepts the completing pixel, which is latency 1.
- `ifmap`, `win_row` and `win_col` hold their last values while `ifmap_valid` = 0. Consumers sample only when `ifmap_valid` = 1.
- Gaps in `pixel_valid` freeze all state; the outputs' valid flags drop to 0 during gaps.
- Back-to-back pixels at the end of row r followed by the start of row r+1 are accepted with no bubble.
- A frame-to-frame transition needs no idle cycle.
- Maximum throughput is one pixel per cycle and at most one window per cycle.

## Test plan
- **Basic frame:** IMG_W=4, IMG_H=4, pixels 0..15 with `pixel_valid` held high.
  - Exactly 4 `ifmap_valid` pulses.
  - First pulse, after pixel 10: bytes 0..8 = 0,1,2,4,5,6,8,9,10, with `win_row`=0 and `win_col`=0.
  - Last pulse, after pixel 15: bytes = 5,6,7,9,10,11,13,14,15, with `win_row`=1, `win_col`=1 and `frame_done`=1.
- **Gapped input:** same frame with `pixel_valid` toggled 1,0,1,0….
  - Identical window sequence and values.
  - Each pulse arrives exactly 1 cycle after its completing pixel.
- **Two frames back-to-back:** frame 2 is pixels 100..115.
  - No window appears from frame-2 rows 0–1.
  - First frame-2 window = 100,101,102,104,105,106,108,109,110.
- **Mid-frame reset:** assert `rst` after pixel 9; check all outputs are 0.
  - Restart with pixels 0..15; windows must match the basic-frame test.
  - Repeat the check with `flush` instead of `rst`.
- **Flush collision:** `flush` and `pixel_valid` in the same cycle.
  - The pixel is dropped.
  - The next pixel is treated as (0,0).
- **Non-square frame:** IMG_W=5, IMG_H=3, pixels 0..14.
  - 3 windows at `win_col` 0,1,2.
  - `frame_done` on the third window, whose bytes = 2,3,4,7,8,9,12,13,14.

Source files
------------

// File: rtl/ifmap_window_gen.sv
// rtl/ifmap_window_gen.sv - streaming 3x3 window generator feeding the pe_tensor ifmap port
module ifmap_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [7:0]                 pixel_in,
  input  logic                       pixel_valid,
  output logic [71:0]                ifmap,
  output logic                       ifmap_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [71:0]   win_q;
  logic [71:0]   win_next;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic          accept;
  logic          win_ok;
  logic          last_px;

  // flush wins over a coincident pixel, so that pixel is simply dropped
  assign accept  = pixel_valid && !flush;
  // windows touching row 0/1 (stale line buffers) or straddling a row wrap are suppressed
  assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));
  assign last_px = (row == ROW_LAST) && (col == COL_LAST);

  // shift the window one column left; the new column {lb1, lb0, pixel} enters at c = 2
  always_comb begin
    win_next = win_q;
    for (int r = 0; r < 3; r++) begin
      win_next[8*(3*r)   +: 8] = win_q[8*(3*r+1) +: 8];
      win_next[8*(3*r+1) +: 8] = win_q[8*(3*r+2) +: 8];
    end
    win_next[8*2 +: 8] = lb1[col];
    win_next[8*5 +: 8] = lb0[col];
    win_next[8*8 +: 8] = pixel_in;
  end

  // line buffers age by one row per accepted pixel; contents are never reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pixel_in;
    end
  end

  // raster counters and the working window register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      win_q <= '0;
    end else if (flush) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      win_q <= win_next;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // registered outputs; data and position hold while the valid pulse is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifmap       <= '0;
      ifmap_valid <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      frame_done  <= 1'b0;
    end else begin
      ifmap_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (accept && win_ok) begin
        ifmap       <= win_next;
        ifmap_valid <= 1'b1;
        win_row     <= row - RW'(2);
        win_col     <= col - CW'(2);
        frame_done  <= last_px;
      end
    end
  end

endmodule

// File: tb/tb_ifmap_window_gen.sv
// tb/tb_ifmap_window_gen.sv - directed self-checking bench for ifmap_window_gen
module tb_ifmap_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  pixel_in = 8'd0;
  logic        pixel_valid = 1'b0;
  logic [71:0] ifmap;
  logic        ifmap_valid;
  logic [1:0]  win_row;
  logic [1:0]  win_col;
  logic        frame_done;

  logic [7:0]  pixel_in2 = 8'd0;
  logic        pixel_valid2 = 1'b0;
  logic [71:0] ifmap2;
  logic        ifmap_valid2;
  logic [1:0]  win_row2;
  logic [2:0]  win_col2;
  logic        frame_done2;

  int checks = 0;
  int failures = 0;

  logic [71:0] first_w, last_w;
  int          pulses;

  always #5 clk = ~clk;

  ifmap_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .ifmap(ifmap), .ifmap_valid(ifmap_valid), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  ifmap_window_gen #(.IMG_W(5), .IMG_H(3)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .pixel_in(pixel_in2), .pixel_valid(pixel_valid2),
    .ifmap(ifmap2), .ifmap_valid(ifmap_valid2), .win_row(win_row2), .win_col(win_col2),
    .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected window completed at (rr, cc) of a 4x4 frame whose pixel (r,c) = base + 4r + c
  function automatic logic [71:0] exp_win(input int base, input int rr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = 8'(base + 4*(rr-2+r) + (cc-2+c));
    return w;
  endfunction

  task automatic send(input logic [7:0] p);
    pixel_in = p;
    pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input int base, input bit gapped,
                           output logic [71:0] fw, output logic [71:0] lw, output int np);
    np = 0;
    fw = '0;
    lw = '0;
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = i / 4;
      c = i % 4;
      send(8'(base + i));
      chk("valid", {71'd0, ifmap_valid}, {71'd0, (r >= 2 && c >= 2)});
      if (r >= 2 && c >= 2) begin
        if (np == 0) fw = ifmap;
        lw = ifmap;
        np++;
        chk("window", ifmap, exp_win(base, r, c));
        chk("win_row", {70'd0, win_row}, 72'(r - 2));
        chk("win_col", {70'd0, win_col}, 72'(c - 2));
        chk("frame_done", {71'd0, frame_done}, {71'd0, (i == 15)});
      end else begin
        chk("frame_done_idle", {71'd0, frame_done}, 72'd0);
      end
      if (gapped) begin
        @(posedge clk);
        #1;
        chk("gap_valid", {71'd0, ifmap_valid}, 72'd0);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ifmap", ifmap, 72'd0);
    chk("rst_valid", {71'd0, ifmap_valid}, 72'd0);
    chk("rst_row", {70'd0, win_row}, 72'd0);
    chk("rst_col", {70'd0, win_col}, 72'd0);
    chk("rst_fd", {71'd0, frame_done}, 72'd0);
    chk("rst_valid2", {71'd0, ifmap_valid2}, 72'd0);

    // basic frame
    run_frame(0, 1'b0, first_w, last_w, pulses);
    chk("basic_pulses", 72'(pulses), 72'd4);
    chk("basic_first", first_w, 72'h0A_09_08_06_05_04_02_01_00);
    chk("basic_last", last_w, 72'h0F_0E_0D_0B_0A_09_07_06_05);

    // gapped input
    run_frame(0, 1'b1, first_w, last_w, pulses);
    chk("gap_pulses", 72'(pulses), 72'd4);
    chk("gap_first", first_w, 72'h0A_09_08_06_05_04_02_01_00);
    chk("gap_last", last_w, 72'h0F_0E_0D_0B_0A_09_07_06_05);

    // two frames back-to-back
    run_frame(0, 1'b0, first_w, last_w, pulses);
    run_frame(100, 1'b0, first_w, last_w, pulses);
    chk("f2_pulses", 72'(pulses), 72'd4);
    chk("f2_first", first_w, 72'h6E_6D_6C_6A_69_68_66_65_64);

    // mid-frame reset
    for (int i = 0; i < 10; i++) send(8'(i));
    rst = 1'b1;
    #1;
    chk("mrst_ifmap", ifmap, 72'd0);
    chk("mrst_valid", {71'd0, ifmap_valid}, 72'd0);
    chk("mrst_row", {70'd0, win_row}, 72'd0);
    chk("mrst_col", {70'd0, win_col}, 72'd0);
    chk("mrst_fd", {71'd0, frame_done}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(0, 1'b0, first_w, last_w, pulses);
    chk("mrst_pulses", 72'(pulses), 72'd4);
    chk("mrst_first", first_w, 72'h0A_09_08_06_05_04_02_01_00);

    // mid-frame flush
    for (int i = 0; i < 10; i++) send(8'(i));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", {71'd0, ifmap_valid}, 72'd0);
    chk("flush_fd", {71'd0, frame_done}, 72'd0);
    run_frame(0, 1'b0, first_w, last_w, pulses);
    chk("flush_pulses", 72'(pulses), 72'd4);
    chk("flush_last", last_w, 72'h0F_0E_0D_0B_0A_09_07_06_05);

    // flush colliding with a pixel: the pixel is dropped
    for (int i = 0; i < 6; i++) send(8'(i));
    flush = 1'b1;
    pixel_in = 8'hEE;
    pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    pixel_valid = 1'b0;
    chk("coll_valid", {71'd0, ifmap_valid}, 72'd0);
    run_frame(0, 1'b0, first_w, last_w, pulses);
    chk("coll_pulses", 72'(pulses), 72'd4);
    chk("coll_first", first_w, 72'h0A_09_08_06_05_04_02_01_00);

    // non-square 5x3 frame on the second instance
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      pixel_in2 = 8'(i);
      pixel_valid2 = 1'b1;
      @(posedge clk);
      #1;
      pixel_valid2 = 1'b0;
      chk("ns_valid", {71'd0, ifmap_valid2}, {71'd0, (i >= 12)});
      if (i >= 12) begin
        chk("ns_col", {69'd0, win_col2}, 72'(i - 12));
        chk("ns_row", {70'd0, win_row2}, 72'd0);
        chk("ns_fd", {71'd0, frame_done2}, {71'd0, (i == 14)});
        pulses++;
      end
    end
    chk("ns_pulses", 72'(pulses), 72'd3);
    chk("ns_last", ifmap2, 72'h0E_0D_0C_09_08_07_04_03_02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
